// File: rtl/codec_avalon_slave.sv
`default_nettype none
// ============================================================================
//  Module   : codec_avalon_slave
//  Purpose  : Avalon-MM slave for an audio codec: I2C packet launch, DAC
//             playback FIFO, ADC capture FIFO, status/control and interrupt.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n                 clock (rising edge), async active-low reset
//    slave_*                    Avalon-MM slave (addr 0..4, 32-bit data,
//                               waitrequest, burst start/count, level irq)
//    i2c_packet/start/busy      24-bit packet, launch pulse, engine busy
//    dac_data/valid/ready       DAC FIFO head, non-empty, consumer pop
//    adc_data/valid             ADC sample and one-cycle push strobe
// ============================================================================
module codec_avalon_slave #(
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        slave_chipselect,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [2:0]  slave_address,
    input  logic [31:0] slave_writedata,
    output logic [31:0] slave_readdata,
    output logic        slave_waitrequest,
    input  logic        slave_beginbursttransfer,
    input  logic [7:0]  slave_burstcount,
    output logic        slave_irq,
    output logic [23:0] i2c_packet,
    output logic        i2c_start,
    input  logic        i2c_busy,
    output logic [31:0] dac_data,
    output logic        dac_valid,
    input  logic        dac_ready,
    input  logic [31:0] adc_data,
    input  logic        adc_valid
);

    localparam int              PTR_W    = (LVL_W > 1) ? LVL_W - 1 : 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic [31:0]      dac_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] dac_wptr_q, dac_rptr_q;
    logic [LVL_W-1:0] dac_lvl_q, dac_lvl_d;
    logic [31:0]      adc_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] adc_wptr_q, adc_rptr_q;
    logic [LVL_W-1:0] adc_lvl_q, adc_lvl_d;

    logic [31:0] i2c_reg_q, dac_last_q, readdata_q, readdata_d;
    logic        i2c_start_q, irq_en_q, ovf_q, ovf_d, irq_q, irq_d;
    logic [5:0]  thr_q;
    logic [7:0]  beat_q, beat_d;
    logic        unused_beat;

    logic w_wait, w_acc, w_wr_acc, w_rd_acc;
    logic w_dac_full, w_dac_empty, w_adc_full, w_adc_empty;
    logic w_dac_push, w_dac_pop, w_adc_push, w_adc_pop, w_ovf_set, w_ovf_clr;
    logic [31:0] w_status, w_ctrl;

    assign w_dac_full  = (dac_lvl_q == FULL_LVL);
    assign w_dac_empty = (dac_lvl_q == '0);
    assign w_adc_full  = (adc_lvl_q == FULL_LVL);
    assign w_adc_empty = (adc_lvl_q == '0);

    // Stall decisions use pre-pop FIFO state so a same-cycle DAC pop never
    // lets a write through a full FIFO.
    always_comb begin
        w_wait = 1'b0;
        if (slave_chipselect) begin
            if (slave_write) begin
                if (slave_address == 3'd0)      w_wait = i2c_busy | i2c_start_q;
                else if (slave_address == 3'd1) w_wait = w_dac_full;
            end else if (slave_read && slave_address == 3'd2) begin
                w_wait = w_adc_empty;
            end
        end
    end

    // Write has priority when read and write are both asserted.
    assign w_acc    = slave_chipselect & (slave_read | slave_write) & ~w_wait;
    assign w_wr_acc = w_acc & slave_write;
    assign w_rd_acc = w_acc & slave_read & ~slave_write;

    assign w_dac_push = w_wr_acc & (slave_address == 3'd1);
    assign w_dac_pop  = dac_valid & dac_ready;
    assign w_adc_pop  = w_rd_acc & (slave_address == 3'd2);
    // A full ADC FIFO still accepts a sample when a pop frees a slot the same cycle.
    assign w_adc_push = adc_valid & (~w_adc_full | w_adc_pop);
    assign w_ovf_set  = adc_valid & w_adc_full & ~w_adc_pop;
    assign w_ovf_clr  = w_wr_acc & (slave_address == 3'd3) & slave_writedata[21];

    assign dac_lvl_d = dac_lvl_q + LVL_W'(w_dac_push) - LVL_W'(w_dac_pop);
    assign adc_lvl_d = adc_lvl_q + LVL_W'(w_adc_push) - LVL_W'(w_adc_pop);
    assign ovf_d     = w_ovf_set | (ovf_q & ~w_ovf_clr);
    assign irq_d     = irq_en_q & ((((8'(adc_lvl_q)) >= {2'b00, thr_q}) && (thr_q != 6'd0)) | ovf_q);

    always_comb begin
        w_status              = '0;
        w_status[LVL_W-1:0]   = dac_lvl_q;
        w_status[8 +: LVL_W]  = adc_lvl_q;
        w_status[16]          = w_dac_full;
        w_status[17]          = w_dac_empty;
        w_status[18]          = w_adc_full;
        w_status[19]          = w_adc_empty;
        w_status[20]          = i2c_busy;
        w_status[21]          = ovf_q;
    end

    assign w_ctrl = {18'd0, thr_q, 7'd0, irq_en_q};

    always_comb begin
        readdata_d = readdata_q;
        if (w_rd_acc) begin
            case (slave_address)
                3'd0:    readdata_d = i2c_reg_q;
                3'd1:    readdata_d = dac_last_q;
                3'd2:    readdata_d = adc_mem_q[adc_rptr_q];
                3'd3:    readdata_d = w_status;
                3'd4:    readdata_d = w_ctrl;
                default: readdata_d = '0;
            endcase
        end
    end

    // Beat counter tracks burst progress only; it never gates an access.
    always_comb begin
        beat_d = beat_q;
        if (slave_beginbursttransfer)
            beat_d = (slave_burstcount == 8'd0) ? 8'd1 : slave_burstcount;
        if (w_acc && beat_d != 8'd0)
            beat_d = beat_d - 8'd1;
    end
    assign unused_beat = ^beat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) dac_mem_q[i] <= '0;
            dac_wptr_q <= '0;
            dac_rptr_q <= '0;
            dac_lvl_q  <= '0;
        end else begin
            if (w_dac_push) begin
                dac_mem_q[dac_wptr_q] <= slave_writedata;
                dac_wptr_q            <= dac_wptr_q + PTR_W'(1);
            end
            if (w_dac_pop) dac_rptr_q <= dac_rptr_q + PTR_W'(1);
            dac_lvl_q <= dac_lvl_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) adc_mem_q[i] <= '0;
            adc_wptr_q <= '0;
            adc_rptr_q <= '0;
            adc_lvl_q  <= '0;
        end else begin
            if (w_adc_push) begin
                adc_mem_q[adc_wptr_q] <= adc_data;
                adc_wptr_q            <= adc_wptr_q + PTR_W'(1);
            end
            if (w_adc_pop) adc_rptr_q <= adc_rptr_q + PTR_W'(1);
            adc_lvl_q <= adc_lvl_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i2c_reg_q   <= '0;
            i2c_start_q <= 1'b0;
            dac_last_q  <= '0;
            irq_en_q    <= 1'b0;
            thr_q       <= '0;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
            readdata_q  <= '0;
            beat_q      <= '0;
        end else begin
            i2c_start_q <= w_wr_acc & (slave_address == 3'd0);
            if (w_wr_acc && slave_address == 3'd0) i2c_reg_q  <= slave_writedata;
            if (w_dac_push)                        dac_last_q <= slave_writedata;
            if (w_wr_acc && slave_address == 3'd4) begin
                irq_en_q <= slave_writedata[0];
                thr_q    <= slave_writedata[13:8];
            end
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
            beat_q     <= beat_d;
        end
    end

    assign slave_readdata    = readdata_q;
    assign slave_waitrequest = w_wait;
    assign slave_irq         = irq_q;
    assign i2c_packet        = i2c_reg_q[23:0];
    assign i2c_start         = i2c_start_q;
    assign dac_data          = dac_mem_q[dac_rptr_q];
    assign dac_valid         = ~w_dac_empty;

endmodule
`default_nettype wire

// File: tb/tb_codec_avalon_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_codec_avalon_slave
//  Purpose  : Self-checking bench for codec_avalon_slave; expected read data
//             and FIFO contents are queued at stimulus time and popped when
//             the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_codec_avalon_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slave_chipselect = 1'b0, slave_read = 1'b0, slave_write = 1'b0;
    logic [2:0]  slave_address = '0;
    logic [31:0] slave_writedata = '0;
    logic [31:0] slave_readdata;
    logic        slave_waitrequest;
    logic        slave_beginbursttransfer = 1'b0;
    logic [7:0]  slave_burstcount = '0;
    logic        slave_irq;
    logic [23:0] i2c_packet;
    logic        i2c_start;
    logic        i2c_busy = 1'b0;
    logic [31:0] dac_data;
    logic        dac_valid;
    logic        dac_ready = 1'b0;
    logic [31:0] adc_data = '0;
    logic        adc_valid = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_q [$];
    logic [31:0] dac_q [$];
    logic [31:0] adc_q [$];

    codec_avalon_slave #(.FIFO_DEPTH(8), .LVL_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .slave_chipselect(slave_chipselect), .slave_read(slave_read),
        .slave_write(slave_write), .slave_address(slave_address),
        .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
        .slave_waitrequest(slave_waitrequest),
        .slave_beginbursttransfer(slave_beginbursttransfer),
        .slave_burstcount(slave_burstcount), .slave_irq(slave_irq),
        .i2c_packet(i2c_packet), .i2c_start(i2c_start), .i2c_busy(i2c_busy),
        .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
        .adc_data(adc_data), .adc_valid(adc_valid)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        int n = 0;
        slave_chipselect = 1'b1; slave_write = 1'b1; slave_read = 1'b0;
        slave_address = a; slave_writedata = d;
        @(negedge clk);
        while (slave_waitrequest && n < 200) begin n++; @(negedge clk); end
        if (n >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL write_timeout addr=%0d got waitrequest=1 expected=0", a);
        end
        @(posedge clk); #1;
        slave_chipselect = 1'b0; slave_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        int n = 0;
        slave_chipselect = 1'b1; slave_read = 1'b1; slave_write = 1'b0;
        slave_address = a;
        @(negedge clk);
        while (slave_waitrequest && n < 200) begin n++; @(negedge clk); end
        if (n >= 200) begin
            n_cmp++; n_fail++;
            $display("FAIL read_timeout addr=%0d got waitrequest=1 expected=0", a);
        end
        @(posedge clk); #1;
        d = slave_readdata;
        slave_chipselect = 1'b0; slave_read = 1'b0;
    endtask

    task automatic push_adc(input logic [31:0] d);
        adc_valid = 1'b1; adc_data = d;
        if (adc_q.size() < 8) adc_q.push_back(d);
        @(posedge clk); #1;
        adc_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (slave_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got=%h exp=0", slave_readdata); end
        n_cmp++; if (slave_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", slave_irq); end
        n_cmp++; if (dac_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dac_valid got=%b exp=0", dac_valid); end
        n_cmp++; if (i2c_start !== 1'b0 || i2c_packet !== 24'h0) begin n_fail++; $display("FAIL reset_i2c got start=%b pkt=%h exp 0/0", i2c_start, i2c_packet); end
        n_cmp++; if (slave_waitrequest !== 1'b0) begin n_fail++; $display("FAIL reset_wait got=%b exp=0", slave_waitrequest); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_i2c();
        logic [31:0] got, e;
        bus_write(3'd0, 32'h001E_0000);
        n_cmp++; if (i2c_start !== 1'b1 || i2c_packet !== 24'h1E0000) begin n_fail++; $display("FAIL i2c_launch got start=%b pkt=%h exp 1/1e0000", i2c_start, i2c_packet); end
        @(posedge clk); #1;
        n_cmp++; if (i2c_start !== 1'b0) begin n_fail++; $display("FAIL i2c_pulse_width got=%b exp=0", i2c_start); end
        exp_q.push_back(32'h001E_0000);
        bus_read(3'd0, got); e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_fail++; $display("FAIL i2c_readback got=%h exp=%h", got, e); end
    endtask

    task automatic test_i2c_busy();
        int stalls = 0;
        i2c_busy = 1'b1;
        slave_chipselect = 1'b1; slave_write = 1'b1; slave_address = 3'd0; slave_writedata = 32'h00AA_BBCC;
        for (int i = 0; i < 5; i++) begin @(negedge clk); if (slave_waitrequest) stalls++; end
        @(posedge clk); #1; i2c_busy = 1'b0;
        n_cmp++; if (stalls !== 5 || i2c_start !== 1'b0) begin n_fail++; $display("FAIL busy_stall got stalls=%0d start=%b exp 5/0", stalls, i2c_start); end
        @(negedge clk);
        n_cmp++; if (slave_waitrequest !== 1'b0) begin n_fail++; $display("FAIL busy_release got wait=%b exp=0", slave_waitrequest); end
        @(posedge clk); #1; slave_chipselect = 1'b0; slave_write = 1'b0;
        n_cmp++; if (i2c_start !== 1'b1 || i2c_packet !== 24'hAABBCC) begin n_fail++; $display("FAIL busy_launch got start=%b pkt=%h exp 1/aabbcc", i2c_start, i2c_packet); end
    endtask

    task automatic test_dac_full();
        logic [31:0] got, e;
        int stalls = 0, drained = 0;
        dac_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin dac_q.push_back(32'h100 + i); bus_write(3'd1, 32'h100 + i); end
        exp_q.push_back(32'h0009_0008);
        bus_read(3'd3, got); e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_fail++; $display("FAIL dac_full_status got=%h exp=%h", got, e); end
        exp_q.push_back(32'h107);
        bus_read(3'd1, got); e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_fail++; $display("FAIL dac_last got=%h exp=%h", got, e); end
        slave_chipselect = 1'b1; slave_write = 1'b1; slave_address = 3'd1; slave_writedata = 32'h108;
        dac_q.push_back(32'h108);
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (slave_waitrequest) stalls++; end
        n_cmp++; if (stalls !== 3) begin n_fail++; $display("FAIL dac_ninth_stall got=%0d exp=3", stalls); end
        @(posedge clk); #1; dac_ready = 1'b1;
        @(negedge clk);
        e = dac_q.pop_front();
        n_cmp++; if (slave_waitrequest !== 1'b1 || dac_data !== e) begin n_fail++; $display("FAIL dac_prepop got wait=%b data=%h exp 1/%h", slave_waitrequest, dac_data, e); end
        @(posedge clk); #1; dac_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (slave_waitrequest !== 1'b0) begin n_fail++; $display("FAIL dac_after_pop got wait=%b exp=0", slave_waitrequest); end
        @(posedge clk); #1; slave_chipselect = 1'b0; slave_write = 1'b0;
        dac_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!dac_valid) break;
            e = dac_q.pop_front(); drained++;
            n_cmp++; if (dac_data !== e) begin n_fail++; $display("FAIL dac_drain got=%h exp=%h", dac_data, e); end
        end
        dac_ready = 1'b0;
        n_cmp++; if (drained !== 8) begin n_fail++; $display("FAIL dac_drain_count got=%0d exp=8", drained); end
        @(posedge clk); #1;
    endtask

    task automatic test_adc_burst();
        logic [31:0] got, e;
        int n;
        slave_chipselect = 1'b1; slave_read = 1'b1; slave_address = 3'd2;
        @(negedge clk);
        n_cmp++; if (slave_waitrequest !== 1'b1) begin n_fail++; $display("FAIL adc_empty_stall got=%b exp=1", slave_waitrequest); end
        @(posedge clk); #1; slave_chipselect = 1'b0; slave_read = 1'b0;
        push_adc(32'hA); push_adc(32'hB); push_adc(32'hC);
        for (int i = 0; i < 3; i++) exp_q.push_back(adc_q.pop_front());
        slave_beginbursttransfer = 1'b1; slave_burstcount = 8'd3;
        slave_chipselect = 1'b1; slave_read = 1'b1; slave_address = 3'd2;
        for (int b = 0; b < 3; b++) begin
            n = 0;
            @(negedge clk);
            while (slave_waitrequest && n < 50) begin n++; @(negedge clk); end
            @(posedge clk); #1;
            slave_beginbursttransfer = 1'b0;
            got = slave_readdata; e = exp_q.pop_front();
            n_cmp++; if (got !== e) begin n_fail++; $display("FAIL adc_burst_beat%0d got=%h exp=%h", b, got, e); end
        end
        slave_chipselect = 1'b0; slave_read = 1'b0;
        exp_q.push_back(32'h000A_0000);
        bus_read(3'd3, got); e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_fail++; $display("FAIL adc_empty_status got=%h exp=%h", got, e); end
    endtask

    task automatic test_irq();
        logic [31:0] got, e;
        bus_write(3'd4, 32'h0000_0401);
        exp_q.push_back(32'h0000_0401);
        bus_read(3'd4, got); e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_fail++; $display("FAIL ctrl_readback got=%h exp=%h", got, e); end
        for (int i = 0; i < 3; i++) push_adc(32'h50 + i);
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (slave_irq !== 1'b0) begin n_fail++; $display("FAIL irq_below_thr got=%b exp=0", slave_irq); end
        push_adc(32'h53);
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (slave_irq !== 1'b1) begin n_fail++; $display("FAIL irq_at_thr got=%b exp=1", slave_irq); end
        exp_q.push_back(adc_q.pop_front());
        bus_read(3'd2, got); e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_fail++; $display("FAIL irq_pop_data got=%h exp=%h", got, e); end
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (slave_irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_pop got=%b exp=0", slave_irq); end
        for (int i = 0; i < 6; i++) push_adc(32'h60 + i);
        bus_write(3'd4, 32'h0000_0001);
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (slave_irq !== 1'b1) begin n_fail++; $display("FAIL irq_ovf got=%b exp=1", slave_irq); end
        exp_q.push_back(32'h0026_0800);
        bus_read(3'd3, got); e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_fail++; $display("FAIL ovf_status got=%h exp=%h", got, e); end
        adc_valid = 1'b1; adc_data = 32'hDEAD;
        bus_write(3'd3, 32'h0020_0000);
        adc_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (slave_irq !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got=%b exp=1", slave_irq); end
        bus_write(3'd3, 32'h0020_0000);
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (slave_irq !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", slave_irq); end
        while (adc_q.size() > 0) begin
            exp_q.push_back(adc_q.pop_front());
            bus_read(3'd2, got); e = exp_q.pop_front();
            n_cmp++; if (got !== e) begin n_fail++; $display("FAIL adc_drain got=%h exp=%h", got, e); end
        end
        exp_q.push_back(32'h000A_0000);
        bus_read(3'd3, got); e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_fail++; $display("FAIL drained_status got=%h exp=%h", got, e); end
    endtask

    task automatic test_reset_midstall();
        logic [31:0] got, e;
        for (int i = 0; i < 4; i++) bus_write(3'd1, 32'h200 + i);
        n_cmp++; if (dac_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_dac_valid got=%b exp=1", dac_valid); end
        i2c_busy = 1'b1;
        slave_chipselect = 1'b1; slave_write = 1'b1; slave_address = 3'd0; slave_writedata = 32'h55;
        @(negedge clk);
        n_cmp++; if (slave_waitrequest !== 1'b1) begin n_fail++; $display("FAIL pre_reset_stall got=%b exp=1", slave_waitrequest); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (slave_readdata !== 32'h0 || dac_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_data got rd=%h dv=%b exp 0/0", slave_readdata, dac_valid); end
        n_cmp++; if (i2c_packet !== 24'h0 || i2c_start !== 1'b0 || slave_irq !== 1'b0) begin n_fail++; $display("FAIL async_reset_ctl got pkt=%h st=%b irq=%b exp 0/0/0", i2c_packet, i2c_start, slave_irq); end
        n_cmp++; if (slave_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_wait_follows got=%b exp=1", slave_waitrequest); end
        slave_chipselect = 1'b0; slave_write = 1'b0; i2c_busy = 1'b0;
        dac_q.delete(); adc_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(32'h000A_0000);
        bus_read(3'd3, got); e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_fail++; $display("FAIL post_reset_status got=%h exp=%h", got, e); end
    endtask

    initial begin
        test_reset();
        test_i2c();
        test_i2c_busy();
        test_dac_full();
        test_adc_burst();
        test_irq();
        test_reset_midstall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
